bit_sync_debounce: RTL and testbench

BIT_SYNC_DEBOUNCE -- requirements
Module: bit_sync_debounce

---
 rtl/bit_sync_debounce.sv | 122 ++++++++++++
 tb/tb_bit_sync_debounce.sv | 275 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/bit_sync_debounce.sv
// -----------------------------------------------------------------------------
// bit_sync_debounce
//
// Per-channel multi-flop synchronizer followed by a consecutive-cycle debounce
// filter, with registered edge pulses and a sticky "filtered value changed"
// flag. All channels are independent; every flop is on the rising edge of
// clck and is cleared by the synchronous active-low reset.
//
// Ports
//   clck        in   sole clock
//   rst         in   synchronous reset, active low
//   async       in   [BUS_WIDTH] asynchronous channel inputs
//   filt_en     in   1 = debounce active, 0 = bypass (filt follows sync)
//   evt_clr     in   [BUS_WIDTH] per-channel clear of evt_sticky
//   sync        out  [BUS_WIDTH] last synchronizer stage
//   filt        out  [BUS_WIDTH] debounced value
//   rise_pulse  out  [BUS_WIDTH] one cycle high when filt goes 0->1
//   fall_pulse  out  [BUS_WIDTH] one cycle high when filt goes 1->0
//   evt_sticky  out  [BUS_WIDTH] latched "filt changed" flag
// -----------------------------------------------------------------------------
module bit_sync_debounce #(
    parameter int BUS_WIDTH  = 1,
    parameter int NUM_STAGES = 3,
    parameter int FILTER_LEN = 4
) (
    input  logic                 clck,
    input  logic                 rst,
    input  logic [BUS_WIDTH-1:0] async,
    input  logic                 filt_en,
    input  logic [BUS_WIDTH-1:0] evt_clr,
    output logic [BUS_WIDTH-1:0] sync,
    output logic [BUS_WIDTH-1:0] filt,
    output logic [BUS_WIDTH-1:0] rise_pulse,
    output logic [BUS_WIDTH-1:0] fall_pulse,
    output logic [BUS_WIDTH-1:0] evt_sticky
);

    localparam int              CNT_W    = $clog2(FILTER_LEN + 1);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(FILTER_LEN - 1);

    generate
        if (NUM_STAGES < 2) begin : g_bad_stages
            $error("bit_sync_debounce: NUM_STAGES must be >= 2");
        end
        if (FILTER_LEN < 1) begin : g_bad_filter
            $error("bit_sync_debounce: FILTER_LEN must be >= 1");
        end
    endgenerate

    logic [BUS_WIDTH-1:0] chain_q [NUM_STAGES];
    logic [CNT_W-1:0]     cnt_q   [BUS_WIDTH];
    logic [CNT_W-1:0]     cnt_d   [BUS_WIDTH];
    logic [BUS_WIDTH-1:0] filt_q,   filt_d;
    logic [BUS_WIDTH-1:0] rise_q,   rise_d;
    logic [BUS_WIDTH-1:0] fall_q,   fall_d;
    logic [BUS_WIDTH-1:0] sticky_q, sticky_d;
    logic [BUS_WIDTH-1:0] sync_w;

    assign sync_w = chain_q[NUM_STAGES-1];

    // Debounce: the counter tracks how many consecutive edges sync has
    // disagreed with filt. It is held at zero in bypass, so re-entering
    // filter mode always starts a fresh count.
    always_comb begin
        filt_d = filt_q;
        for (int i = 0; i < BUS_WIDTH; i++) begin
            cnt_d[i] = '0;
            if (!filt_en) begin
                filt_d[i] = sync_w[i];
            end else if (sync_w[i] != filt_q[i]) begin
                if (cnt_q[i] == CNT_LAST) begin
                    filt_d[i] = sync_w[i];
                end else begin
                    cnt_d[i] = cnt_q[i] + CNT_W'(1);
                end
            end
        end
    end

    // Pulses are registered alongside filt so they coincide with the cycle
    // in which the new filt value is first visible.
    always_comb begin
        rise_d   = filt_d & ~filt_q;
        fall_d   = ~filt_d & filt_q;
        // A fresh update takes priority over a simultaneous clear.
        sticky_d = (filt_d ^ filt_q) | (sticky_q & ~evt_clr);
    end

    always_ff @(posedge clck) begin
        if (!rst) begin
            for (int s = 0; s < NUM_STAGES; s++) begin
                chain_q[s] <= '0;
            end
            for (int i = 0; i < BUS_WIDTH; i++) begin
                cnt_q[i] <= '0;
            end
            filt_q   <= '0;
            rise_q   <= '0;
            fall_q   <= '0;
            sticky_q <= '0;
        end else begin
            chain_q[0] <= async;
            for (int s = 1; s < NUM_STAGES; s++) begin
                chain_q[s] <= chain_q[s-1];
            end
            for (int i = 0; i < BUS_WIDTH; i++) begin
                cnt_q[i] <= cnt_d[i];
            end
            filt_q   <= filt_d;
            rise_q   <= rise_d;
            fall_q   <= fall_d;
            sticky_q <= sticky_d;
        end
    end

    assign sync       = sync_w;
    assign filt       = filt_q;
    assign rise_pulse = rise_q;
    assign fall_pulse = fall_q;
    assign evt_sticky = sticky_q;

endmodule

// File: tb/tb_bit_sync_debounce.sv
// -----------------------------------------------------------------------------
// tb_bit_sync_debounce
//
// Directed stimulus for a 4-channel instance (3 synchronizer stages, filter
// length 4). A history-based reference model predicts every output from the
// recorded input history; one compare process checks it on every cycle, and
// the directed sequence adds literal expectations at the interesting edges.
// -----------------------------------------------------------------------------
module tb_bit_sync_debounce;

    localparam int BW   = 4;
    localparam int NS   = 3;
    localparam int FL   = 4;
    localparam int MAXE = 4096;

    logic          clck;
    logic          rst;
    logic [BW-1:0] async;
    logic          filt_en;
    logic [BW-1:0] evt_clr;
    logic [BW-1:0] sync;
    logic [BW-1:0] filt;
    logic [BW-1:0] rise_pulse;
    logic [BW-1:0] fall_pulse;
    logic [BW-1:0] evt_sticky;

    bit_sync_debounce #(
        .BUS_WIDTH  (BW),
        .NUM_STAGES (NS),
        .FILTER_LEN (FL)
    ) dut (
        .clck       (clck),
        .rst        (rst),
        .async      (async),
        .filt_en    (filt_en),
        .evt_clr    (evt_clr),
        .sync       (sync),
        .filt       (filt),
        .rise_pulse (rise_pulse),
        .fall_pulse (fall_pulse),
        .evt_sticky (evt_sticky)
    );

    initial clck = 1'b0;
    always #5 clck = ~clck;

    int n_checks = 0;
    int n_fail   = 0;

    task automatic chk(input string name, input logic [BW-1:0] act, input logic [BW-1:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h, expected %h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // ---------------- reference model (input history based) ----------------
    logic [BW-1:0] h_async [MAXE];
    logic          h_rst   [MAXE];
    logic          h_en    [MAXE];
    logic [BW-1:0] h_clr   [MAXE];
    logic [BW-1:0] m_sync  [MAXE];
    logic [BW-1:0] m_filt  [MAXE];
    logic [BW-1:0] m_rise  [MAXE];
    logic [BW-1:0] m_fall  [MAXE];
    logic [BW-1:0] m_stk   [MAXE];
    int k = 0;

    // sync after edge e is the input sampled NS-1 edges earlier, unless a
    // reset edge lies in that window.
    function automatic logic [BW-1:0] sync_after(input int e);
        if (e < 0) return '0;
        for (int j = e - NS + 1; j <= e; j++) begin
            if (j < 0) return '0;
            if (!h_rst[j]) return '0;
        end
        return h_async[e - NS + 1];
    endfunction

    // True when the last FL edges up to e were all out of reset, in filter
    // mode, and saw channel ch of sync differing from the held value pf.
    function automatic bit run_ok(input int e, input int ch, input logic pf);
        logic [BW-1:0] s;
        for (int j = e - FL + 1; j <= e; j++) begin
            if (j < 0) return 1'b0;
            if (!h_rst[j] || !h_en[j]) return 1'b0;
            s = sync_after(j - 1);
            if (s[ch] == pf) return 1'b0;
        end
        return 1'b1;
    endfunction

    always @(posedge clck) begin
        logic [BW-1:0] pf, ps, nf;
        if (k < MAXE) begin
            h_async[k] = async;
            h_rst[k]   = rst;
            h_en[k]    = filt_en;
            h_clr[k]   = evt_clr;
            pf = (k > 0) ? m_filt[k-1] : '0;
            ps = (k > 0) ? m_stk[k-1]  : '0;
            m_sync[k] = sync_after(k);
            if (!rst) begin
                nf = '0;
            end else if (!filt_en) begin
                nf = sync_after(k - 1);
            end else begin
                for (int i = 0; i < BW; i++) begin
                    nf[i] = run_ok(k, i, pf[i]) ? ~pf[i] : pf[i];
                end
            end
            m_filt[k] = nf;
            m_rise[k] = rst ? (nf & ~pf) : '0;
            m_fall[k] = rst ? (~nf & pf) : '0;
            m_stk[k]  = rst ? ((nf ^ pf) | (ps & ~evt_clr)) : '0;
            k++;
        end
    end

    always @(negedge clck) begin
        if (k > 0 && k <= MAXE) begin
            chk("model_sync", sync,       m_sync[k-1]);
            chk("model_filt", filt,       m_filt[k-1]);
            chk("model_rise", rise_pulse, m_rise[k-1]);
            chk("model_fall", fall_pulse, m_fall[k-1]);
            chk("model_stky", evt_sticky, m_stk[k-1]);
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic step(input int n);
        repeat (n) @(negedge clck);
    endtask

    localparam int NT = 11;
    localparam logic [BW-1:0] T_A   [NT] = '{4'h5, 4'h0, 4'h5, 4'h5, 4'h5, 4'hA, 4'hA, 4'h3, 4'h3, 4'h0, 4'h0};
    localparam logic          T_EN  [NT] = '{1'b1, 1'b1, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 1'b1};
    localparam logic [BW-1:0] T_CLR [NT] = '{4'h0, 4'h0, 4'h0, 4'h0, 4'h0, 4'h1, 4'h0, 4'h0, 4'hF, 4'h0, 4'h0};
    localparam int            T_N   [NT] = '{2, 6, 5, 1, 8, 3, 2, 10, 2, 4, 6};

    initial begin
        rst     = 1'b0;
        async   = 4'hF;
        filt_en = 1'b1;
        evt_clr = 4'h0;

        // Power-up: reset two edges with all inputs high, then release.
        step(2);
        chk("rst_filt", filt, 4'h0);
        chk("rst_stky", evt_sticky, 4'h0);
        rst = 1'b1;
        step(3);
        chk("up_sync_e3", sync, 4'hF);
        chk("up_filt_e3", filt, 4'h0);
        step(3);
        chk("up_filt_e6", filt, 4'h0);
        step(1);
        chk("up_filt_e7", filt, 4'hF);
        chk("up_rise_e7", rise_pulse, 4'hF);
        chk("up_stky_e7", evt_sticky, 4'hF);
        step(1);
        chk("up_rise_e8", rise_pulse, 4'h0);

        // Clear sticky, then fall with a clear arriving on the update edge.
        evt_clr = 4'hF;
        step(1);
        chk("clr_stky", evt_sticky, 4'h0);
        evt_clr = 4'h0;
        async   = 4'h0;
        step(6);
        chk("fall_filt_e6", filt, 4'hF);
        evt_clr = 4'hF;
        step(1);
        chk("fall_filt_e7", filt, 4'h0);
        chk("fall_pulse_e7", fall_pulse, 4'hF);
        chk("fall_setwins", evt_sticky, 4'hF);
        step(1);
        chk("fall_stky_e8", evt_sticky, 4'h0);
        chk("fall_pulse_e8", fall_pulse, 4'h0);
        evt_clr = 4'h0;

        // Glitch of two cycles on channel 0 must be rejected.
        async = 4'h1;
        step(2);
        async = 4'h0;
        step(1);
        chk("glitch_sync_e3", sync, 4'h1);
        step(1);
        chk("glitch_sync_e4", sync, 4'h1);
        step(1);
        chk("glitch_sync_e5", sync, 4'h0);
        step(7);
        chk("glitch_filt", filt, 4'h0);
        chk("glitch_stky", evt_sticky, 4'h0);

        // Bypass: channel 2 rises after NS+1 edges.
        filt_en = 1'b0;
        async   = 4'h4;
        step(3);
        chk("byp_filt_e3", filt, 4'h0);
        step(1);
        chk("byp_filt_e4", filt, 4'h4);
        chk("byp_rise_e4", rise_pulse, 4'h4);
        step(1);
        chk("byp_rise_e5", rise_pulse, 4'h0);
        async = 4'h0;
        step(5);
        chk("byp_filt_low", filt, 4'h0);
        evt_clr = 4'hF;
        step(1);
        evt_clr = 4'h0;
        filt_en = 1'b1;
        step(2);

        // Reset lands on the edge that would have completed the count.
        async = 4'hF;
        step(6);
        chk("mid_filt_e6", filt, 4'h0);
        rst = 1'b0;
        step(1);
        chk("mid_rst_filt", filt, 4'h0);
        chk("mid_rst_rise", rise_pulse, 4'h0);
        chk("mid_rst_sync", sync, 4'h0);
        rst = 1'b1;
        step(1);
        chk("mid_rel_rise", rise_pulse, 4'h0);
        step(5);
        chk("mid_rel_e6", filt, 4'h0);
        step(1);
        chk("mid_rel_e7", filt, 4'hF);
        chk("mid_rel_rise7", rise_pulse, 4'hF);
        chk("mid_rel_stky", evt_sticky, 4'hF);

        // Independent channels: ch3 at cycle 0, ch1 at cycle 2.
        async = 4'h0;
        step(10);
        evt_clr = 4'hF;
        step(1);
        evt_clr = 4'h0;
        chk("ind_start", filt, 4'h0);
        async = 4'h8;
        step(2);
        async = 4'hA;
        step(4);
        chk("ind_filt_e6", filt, 4'h0);
        step(1);
        chk("ind_filt_e7", filt, 4'h8);
        chk("ind_rise_e7", rise_pulse, 4'h8);
        step(1);
        chk("ind_rise_e8", rise_pulse, 4'h0);
        step(1);
        chk("ind_filt_e9", filt, 4'hA);
        chk("ind_rise_e9", rise_pulse, 4'h2);

        // Mixed directed vectors incl. mode toggles mid-count; model-checked.
        for (int t = 0; t < NT; t++) begin
            async   = T_A[t];
            filt_en = T_EN[t];
            evt_clr = T_CLR[t];
            step(T_N[t]);
        end
        evt_clr = 4'h0;
        step(10);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
